// File: rtl/audio_mixer_dsm_dac.sv
// Multi-channel gain/mix front end driving a 1st- or 2nd-order delta-sigma DAC bitstream.
// Optional LFSR dither on the modulator input: define AUDIO_MIXER_DSM_DAC_DITHER_EN.
module audio_mixer_dsm_dac #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GAIN_WIDTH = 8,
  parameter int unsigned DSM_ORDER  = 1
) (
  input  logic                             clk_i,
  input  logic                             arstn_i,
  input  logic                             sample_valid_i,
  output logic                             sample_ready_o,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   samples_i,
  input  logic [CHANNELS*GAIN_WIDTH-1:0]   gains_i,
  input  logic                             mute_i,
  output logic [DATA_WIDTH-1:0]            mix_o,
  output logic                             mix_valid_o,
  output logic                             clip_o,
  output logic                             output_o
);

  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int unsigned CW = $clog2(CHANNELS);
  localparam int unsigned AW = PW + CW + 1;
  localparam int unsigned SW = AW - GAIN_WIDTH;
  localparam int unsigned IW = (CHANNELS > 1) ? CW : 1;

  typedef enum logic [1:0] {IDLE, MAC, SCALE} state_e;

  state_e                           state_q, state_d;
  logic [CHANNELS*DATA_WIDTH-1:0]   samp_q, samp_d;
  logic [CHANNELS*GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [AW-1:0]                    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]            mix_q, mix_d;
  logic                             clip_q, clip_d;

  logic [PW-1:0]                    prod;
  logic [AW-1:0]                    acc_sum;
  logic [SW-1:0]                    scaled;
  logic                             last_ch;
  logic                             sat;

  // FSM: state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_valid_i) state_d = MAC;
      MAC:     if (last_ch)        state_d = SCALE;
      SCALE:                       state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    sample_ready_o = (state_q == IDLE);
    mix_valid_o    = (state_q == SCALE);
    clip_o         = (state_q == SCALE) && clip_q;
  end

  assign mix_o = mix_q;

  always_comb begin
    prod    = PW'(samp_q[idx_q*DATA_WIDTH +: DATA_WIDTH]) * PW'(gain_q[idx_q*GAIN_WIDTH +: GAIN_WIDTH]);
    acc_sum = acc_q + AW'(prod);
    scaled  = acc_sum[AW-1:GAIN_WIDTH];
    sat     = |scaled[SW-1:DATA_WIDTH];
    last_ch = (idx_q == IW'(CHANNELS - 1));
  end

  // The scale/saturate step is folded into the final MAC cycle so that mix_o
  // is already updated during SCALE, where mix_valid_o is high.
  always_comb begin
    samp_d = samp_q;
    gain_d = gain_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    mix_d  = mix_q;
    clip_d = clip_q;
    unique case (state_q)
      IDLE: begin
        if (sample_valid_i) begin
          samp_d = samples_i;
          gain_d = gains_i;
          idx_d  = '0;
          acc_d  = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (last_ch) begin
          mix_d  = sat ? '1 : scaled[DATA_WIDTH-1:0];
          clip_d = sat;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      samp_q <= '0;
      gain_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      mix_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      gain_q <= gain_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      mix_q  <= mix_d;
      clip_q <= clip_d;
    end
  end

  logic [DATA_WIDTH-1:0] x;

`ifdef AUDIO_MIXER_DSM_DAC_DITHER_EN
  logic [15:0]         lfsr_q, lfsr_d;
  logic [DATA_WIDTH:0] dsum;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    dsum   = {1'b0, mix_q} + (DATA_WIDTH+1)'(lfsr_q[1:0]);
    if (mute_i)       x = '0;
    else if (dsum[DATA_WIDTH]) x = '1;
    else              x = dsum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  always_comb x = mute_i ? '0 : mix_q;
`endif

  if (DSM_ORDER == 1) begin : g_dsm1
    logic [DATA_WIDTH:0] a_q, a_d;
    logic                out_q;

    always_comb a_d = {1'b0, a_q[DATA_WIDTH-1:0]} + {1'b0, x};

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        a_q   <= '0;
        out_q <= 1'b0;
      end else begin
        a_q   <= a_d;
        out_q <= a_q[DATA_WIDTH];
      end
    end

    assign output_o = out_q;
  end else if (DSM_ORDER == 2) begin : g_dsm2
    localparam int unsigned IN = DATA_WIDTH + 4;
    localparam int unsigned EW = DATA_WIDTH + 6;
    localparam logic signed [EW-1:0] HI = {{(EW-IN+1){1'b0}}, {(IN-1){1'b1}}};
    localparam logic signed [EW-1:0] LO = {{(EW-IN+1){1'b1}}, {(IN-1){1'b0}}};

    logic signed [IN-1:0] i1_q, i1_d, i2_q, i2_d;
    logic signed [EW-1:0] i1e, i2e, xe, fb, s1, s2;
    logic                 out_q, out_d;

    function automatic logic signed [IN-1:0] clamp(input logic signed [EW-1:0] v);
      if (v > HI)      return HI[IN-1:0];
      else if (v < LO) return LO[IN-1:0];
      else             return v[IN-1:0];
    endfunction

    always_comb begin
      i1e   = {{(EW-IN){i1_q[IN-1]}}, i1_q};
      i2e   = {{(EW-IN){i2_q[IN-1]}}, i2_q};
      xe    = {{(EW-DATA_WIDTH){1'b0}}, x};
      fb    = {{(EW-DATA_WIDTH-1){1'b0}}, out_q, {DATA_WIDTH{1'b0}}};
      s1    = i1e + xe - fb;
      s2    = i2e + i1e - fb;
      i1_d  = clamp(s1);
      i2_d  = clamp(s2);
      out_d = ~i2_d[IN-1];
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        i1_q  <= '0;
        i2_q  <= '0;
        out_q <= 1'b0;
      end else begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        out_q <= out_d;
      end
    end

    assign output_o = out_q;
  end else begin : g_bad_order
    $error("audio_mixer_dsm_dac: DSM_ORDER must be 1 or 2");
  end

endmodule
